tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter TERM, default 8'h0A: message terminator byte.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum bytes per grant (1..255).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-005 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port i_valid, input, NREQ: per-requester byte valid.
REQ-007 SHALL have port i_data, input, 8*NREQ: requester n's byte on bits [8n+7:8n].
REQ-008 SHALL have port o_ready, output, NREQ: per-requester byte accept.
REQ-009 SHALL have port i_tx_ready, input, 1: the downstream UART transmitter accepts a byte.
REQ-010 SHALL have port o_tx_valid, output, 1: registered byte valid to the transmitter.
REQ-011 SHALL have port o_tx_data, output, 8: registered byte to the transmitter.
REQ-012 SHALL have port o_grant, output, clog2(NREQ): current or last grant index.
REQ-013 SHALL have port o_busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, PREFIX, XFER and RELEASE.
REQ-015 Downstream transfer SHALL occur when o_tx_valid and i_tx_ready are both high; o_tx_valid and o_tx_data SHALL hold stable until that transfer.
REQ-016 Upstream transfer SHALL occur when i_valid[g] and o_ready[g] are both high, where g = o_grant.
REQ-017 o_ready[g] SHALL be combinational and high only in XFER with (!o_tx_valid || i_tx_ready); o_ready SHALL be 0 for all other requesters.
REQ-018 An accepted byte SHALL appear on o_tx_data with o_tx_valid = 1 in the next cycle (1-cycle latency, no bubble at full throughput).
REQ-019 IDLE SHALL choose g as the first n with i_valid[n] = 1, searching round-robin from last_grant+1 and wrapping at NREQ-1 to 0, then go to XFER (or PREFIX, see REQ-030); the state SHALL remain IDLE if no i_valid bit is set.
REQ-020 The byte counter SHALL clear on grant and increment on each upstream transfer.
REQ-021 XFER SHALL go to RELEASE in the cycle after accepting a byte equal to TERM, or after accepting the byte that makes the count equal MAX_BURST; that byte SHALL still be forwarded.
REQ-022 An idle granted requester (i_valid[g] = 0) SHALL keep the grant; there is no timeout.
REQ-023 RELEASE SHALL wait until o_tx_valid = 0 or a downstream transfer occurs, then set last_grant = g and go to IDLE.
REQ-024 A new arbitration SHALL take place no earlier than the cycle after returning to IDLE; messages from different requesters SHALL never interleave.
REQ-025 Requests asserted by several requesters in the same cycle SHALL be resolved by the round-robin order only.

Reset
REQ-026 On a clk edge with i_reset = 1, state SHALL become IDLE, and o_tx_valid, o_tx_data, the byte counter and o_grant SHALL become 0.
REQ-027 Reset SHALL set last_grant = NREQ-1, so requester 0 wins first.
REQ-028 Reset mid-message SHALL drop any pending output byte; o_ready SHALL be all-zero during reset.

Configuration
REQ-029 The macro TX_ARBITER_PREFIX_EN SHALL control the source-ID prefix.
REQ-030 When TX_ARBITER_PREFIX_EN is defined, grant SHALL enter PREFIX, which loads o_tx_data = 8'h30 + g (ASCII digit) with o_tx_valid = 1 once the output register is free, then goes to XFER; the prefix SHALL NOT count toward MAX_BURST.
REQ-031 When TX_ARBITER_PREFIX_EN is undefined, PREFIX SHALL be absent and grant SHALL go directly to XFER.

Verification
REQ-032 Reset, then requester 1 sends "AB\n" with i_tx_ready held 1 -> output 41,42,0A on consecutive cycles; o_grant = 1; return to IDLE.
REQ-033 Requesters 0 and 2 both valid at reset exit, each sending "x\n" -> all of requester 0's message, then all of requester 2's; never interleaved.
REQ-034 Requester 3 streams 20 non-TERM bytes, MAX_BURST = 16 -> release after the 16th byte; if requester 0 is also waiting it is granted next, else requester 3 is re-granted.
REQ-035 i_tx_ready = 0 for 5 cycles mid-message -> o_tx_data is held stable, o_ready[g] = 0, and no bytes are lost or duplicated.
REQ-036 i_reset pulsed while in XFER -> next cycle o_tx_valid = 0, o_busy = 0, and requester 0 wins the next arbitration.
REQ-037 With TX_ARBITER_PREFIX_EN defined, requester 2 sends "Z\n" -> output 32,5A,0A.

Source files
------------

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that merges whole messages from NREQ byte sources onto one
// registered UART transmit stream. Optional source-ID prefix byte: TX_ARBITER_PREFIX_EN.
module tx_arbiter #(
    parameter int          NREQ      = 4,
    parameter logic [7:0]  TERM      = 8'h0A,
    parameter int          MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic [NREQ-1:0]         i_valid,
    input  logic [8*NREQ-1:0]       i_data,
    output logic [NREQ-1:0]         o_ready,
    input  logic                    i_tx_ready,
    output logic                    o_tx_valid,
    output logic [7:0]              o_tx_data,
    output logic [$clog2(NREQ)-1:0] o_grant,
    output logic                    o_busy
);

    localparam int GW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
`ifdef TX_ARBITER_PREFIX_EN
        PREFIX  = 2'd1,
`endif
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_tx_valid;
    logic [7:0]      r_tx_data;
    logic [7:0]      r_count;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_last_grant;

    logic [GW-1:0]   w_pick;
    logic            w_any_req;
    logic            w_out_free;
    logic            w_ready_en;
    logic            w_sel_valid;
    logic [7:0]      w_sel_data;
    logic            w_up_xfer;
    logic            w_last_byte;

    // Output register can take a new byte when empty or being drained this cycle.
    assign w_out_free  = !r_tx_valid || i_tx_ready;
    assign w_ready_en  = (r_state == XFER) && w_out_free && !i_reset;
    assign w_up_xfer   = w_ready_en && w_sel_valid;
    assign w_last_byte = (w_sel_data == TERM) || (r_count == 8'(MAX_BURST - 1));

    // Round-robin search starting just after the previous winner.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_pick    = r_last_grant;
        w_any_req = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(r_last_grant) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_any_req && i_valid[GW'(idx)]) begin
                w_pick    = GW'(idx);
                w_any_req = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = 8'h00;
        for (int n = 0; n < NREQ; n++) begin
            o_ready[n] = w_ready_en && (r_grant == GW'(n));
            if (r_grant == GW'(n)) begin
                w_sel_valid = i_valid[n];
                w_sel_data  = i_data[8*n +: 8];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
`ifdef TX_ARBITER_PREFIX_EN
                    w_next_state = PREFIX;
`else
                    w_next_state = XFER;
`endif
                end
            end
`ifdef TX_ARBITER_PREFIX_EN
            PREFIX: begin
                if (w_out_free) begin
                    w_next_state = XFER;
                end
            end
`endif
            XFER: begin
                if (w_up_xfer && w_last_byte) begin
                    w_next_state = RELEASE;
                end
            end
            RELEASE: begin
                if (w_out_free) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_count      <= 8'h00;
            r_grant      <= '0;
            r_last_grant <= GW'(NREQ - 1);
        end else begin
            if (w_up_xfer) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_sel_data;
            end
`ifdef TX_ARBITER_PREFIX_EN
            else if (r_state == PREFIX && w_out_free) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= 8'h30 + 8'(r_grant);
            end
`endif
            else if (i_tx_ready) begin
                r_tx_valid <= 1'b0;
            end

            if (r_state == IDLE && w_any_req) begin
                r_grant <= w_pick;
                r_count <= 8'h00;
            end else if (w_up_xfer) begin
                r_count <= r_count + 8'h01;
            end

            if (r_state == RELEASE && w_out_free) begin
                r_last_grant <= r_grant;
            end
        end
    end

    assign o_tx_valid = r_tx_valid;
    assign o_tx_data  = r_tx_data;
    assign o_grant    = r_grant;
    assign o_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: byte queues feed the requesters, a monitor logs
// every downstream transfer, and the main sequence checks the log against hand-built messages.
module tb_tx_arbiter;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_tx_ready;
    logic [3:0]  i_valid = '0;
    logic [31:0] i_data  = '0;
    logic [3:0]  o_ready;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic [1:0]  o_grant;
    logic        o_busy;

    logic [7:0]  q [4][$];
    logic [7:0]  log_d [$];
    logic [1:0]  log_g [$];
    int          log_c [$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          base;

    tx_arbiter dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .i_tx_ready (i_tx_ready),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .o_grant    (o_grant),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    // Sources present queue heads at negedge; transfers for the coming posedge are logged once settled.
    always @(negedge clk) begin
        for (int n = 0; n < 4; n++) begin
            i_valid[n]       = (q[n].size() > 0);
            i_data[8*n +: 8] = (q[n].size() > 0) ? q[n][0] : 8'h00;
        end
        #1;
        if (o_tx_valid && i_tx_ready) begin
            log_d.push_back(o_tx_data);
            log_g.push_back(o_grant);
            log_c.push_back(cyc);
        end
        for (int n = 0; n < 4; n++) begin
            if (i_valid[n] && o_ready[n]) begin
                void'(q[n].pop_front());
            end
        end
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish within 500000 time units");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_str(input int n, input string s);
        for (int i = 0; i < s.len(); i++) begin
            q[n].push_back(s[i]);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            tick();
            done = (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0) &&
                   (q[3].size() == 0) && !o_busy && !o_tx_valid;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_log(input string tag, input int target, input int budget);
        logic done;
        done = (log_d.size() >= target);
        for (int k = 0; k < budget && !done; k++) begin
            tick();
            done = (log_d.size() >= target);
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic expect_out(input string tag, input int idx, input logic [7:0] d, input logic [1:0] g);
        logic [7:0] gd;
        logic [1:0] gg;
        gd = 'x;
        gg = 'x;
        if (idx < log_d.size()) begin
            gd = log_d[idx];
            gg = log_g[idx];
        end
        check({tag, "_data"}, {24'd0, gd}, {24'd0, d});
        check({tag, "_grant"}, {30'd0, gg}, {30'd0, g});
    endtask

    initial begin
        i_reset    = 1'b1;
        i_tx_ready = 1'b1;
        repeat (3) tick();
        #1;
        check("rst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
        check("rst_grant", {30'd0, o_grant}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_ready", {28'd0, o_ready}, 32'd0);
        i_reset = 1'b0;
        tick();

`ifdef TX_ARBITER_PREFIX_EN
        // Requester 2 sends "Z\n" preceded by its ASCII ID.
        base = log_d.size();
        push_str(2, "Z\n");
        wait_idle("pfx_idle", 100);
        check("pfx_len", log_d.size() - base, 3);
        expect_out("pfx0", base + 0, 8'h32, 2'd2);
        expect_out("pfx1", base + 1, 8'h5A, 2'd2);
        expect_out("pfx2", base + 2, 8'h0A, 2'd2);
        check("pfx_back2back", log_c[base + 2] - log_c[base], 2);
`else
        // Requester 1 sends "AB\n" at full throughput.
        base = log_d.size();
        push_str(1, "AB\n");
        wait_idle("ab_idle", 100);
        check("ab_len", log_d.size() - base, 3);
        expect_out("ab0", base + 0, 8'h41, 2'd1);
        expect_out("ab1", base + 1, 8'h42, 2'd1);
        expect_out("ab2", base + 2, 8'h0A, 2'd1);
        check("ab_back2back", log_c[base + 2] - log_c[base], 2);
        check("ab_grant_kept", {30'd0, o_grant}, 32'd1);

        // Requesters 0 and 2 both pending at reset exit: 0 first, whole messages.
        i_reset = 1'b1;
        base = log_d.size();
        push_str(0, "x\n");
        push_str(2, "x\n");
        repeat (2) tick();
        i_reset = 1'b0;
        wait_idle("rr_idle", 100);
        check("rr_len", log_d.size() - base, 4);
        expect_out("rr0", base + 0, 8'h78, 2'd0);
        expect_out("rr1", base + 1, 8'h0A, 2'd0);
        expect_out("rr2", base + 2, 8'h78, 2'd2);
        expect_out("rr3", base + 3, 8'h0A, 2'd2);

        // Requester 3 streams 20 non-TERM bytes alone: burst cut at 16, then re-granted.
        base = log_d.size();
        for (int i = 0; i < 20; i++) q[3].push_back(8'h41 + 8'(i));
        wait_log("burst_20", base + 20, 200);
        for (int i = 0; i < 20; i++) expect_out("burst", base + i, 8'h41 + 8'(i), 2'd3);
        check("burst_first16_b2b", log_c[base + 15] - log_c[base], 15);
        check("burst_regrant_gap", log_c[base + 16] - log_c[base + 15], 3);
        // Idle grant is kept: requester 0 must wait until requester 3 terminates.
        push_str(0, "0\n");
        repeat (10) tick();
        check("hold_no_out", log_d.size() - base, 20);
        check("hold_busy", {31'd0, o_busy}, 32'd1);
        check("hold_grant", {30'd0, o_grant}, 32'd3);
        q[3].push_back(8'h0A);
        wait_idle("hold_idle", 100);
        expect_out("hold_term", base + 20, 8'h0A, 2'd3);
        expect_out("hold_r0a", base + 21, 8'h30, 2'd0);
        expect_out("hold_r0b", base + 22, 8'h0A, 2'd0);

        // Burst cut with requester 0 waiting: 0 is granted before 3 resumes.
        base = log_d.size();
        for (int i = 0; i < 16; i++) q[3].push_back(8'h61 + 8'(i));
        q[3].push_back(8'h0A);
        push_str(0, "0\n");
        wait_idle("cut_idle", 200);
        check("cut_len", log_d.size() - base, 19);
        for (int i = 0; i < 16; i++) expect_out("cut", base + i, 8'h61 + 8'(i), 2'd3);
        expect_out("cut_r0a", base + 16, 8'h30, 2'd0);
        expect_out("cut_r0b", base + 17, 8'h0A, 2'd0);
        expect_out("cut_r3", base + 18, 8'h0A, 2'd3);

        // Transmitter stalls for 5 cycles mid-message.
        base = log_d.size();
        push_str(1, "HELLO\n");
        wait_log("stall_start", base + 2, 100);
        i_tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_valid", {31'd0, o_tx_valid}, 32'd1);
            check("stall_data", {24'd0, o_tx_data}, 32'h4C);
            check("stall_ready", {28'd0, o_ready}, 32'd0);
            tick();
        end
        check("stall_no_out", log_d.size() - base, 2);
        i_tx_ready = 1'b1;
        wait_idle("stall_idle", 100);
        check("stall_len", log_d.size() - base, 6);
        expect_out("stall0", base + 0, 8'h48, 2'd1);
        expect_out("stall1", base + 1, 8'h45, 2'd1);
        expect_out("stall2", base + 2, 8'h4C, 2'd1);
        expect_out("stall3", base + 3, 8'h4C, 2'd1);
        expect_out("stall4", base + 4, 8'h4F, 2'd1);
        expect_out("stall5", base + 5, 8'h0A, 2'd1);

        // Reset mid-message drops the pending byte; requester 0 then wins.
        base = log_d.size();
        push_str(2, "PQRS\n");
        wait_log("mrst_start", base + 1, 100);
        i_reset    = 1'b1;
        i_tx_ready = 1'b0;
        push_str(0, "0\n");
        #1;
        check("mrst_ready", {28'd0, o_ready}, 32'd0);
        tick();
        i_reset    = 1'b0;
        i_tx_ready = 1'b1;
        check("mrst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
        check("mrst_tx_data", {24'd0, o_tx_data}, 32'd0);
        check("mrst_busy", {31'd0, o_busy}, 32'd0);
        check("mrst_grant", {30'd0, o_grant}, 32'd0);
        wait_idle("mrst_idle", 100);
        check("mrst_len", log_d.size() - base, 6);
        expect_out("mrst0", base + 0, 8'h50, 2'd2);
        expect_out("mrst1", base + 1, 8'h30, 2'd0);
        expect_out("mrst2", base + 2, 8'h0A, 2'd0);
        expect_out("mrst3", base + 3, 8'h52, 2'd2);
        expect_out("mrst4", base + 4, 8'h53, 2'd2);
        expect_out("mrst5", base + 5, 8'h0A, 2'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
